// File: rtl/exec_pkg.sv
// exec_pkg: op-codes, FSM encoding, carried control bundle and width helper
// shared by the execute stage and its multiplier.
package exec_pkg;
   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_ROL   = 4'd8;
   localparam logic [3:0] OP_SLT   = 4'd9;
   localparam logic [3:0] OP_SEQ   = 4'd10;
   localparam logic [3:0] OP_SLE   = 4'd11;
   localparam logic [3:0] OP_PASSA = 4'd12;
   localparam logic [3:0] OP_PASSB = 4'd13;
   localparam logic [3:0] OP_MUL   = 4'd14;

   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_e;

   typedef struct packed {
      logic regwrite;
      logic memwrite;
      logic memen;
      logic memtoreg;
      logic dump;
   } ctrl_t;

   function automatic int log2w(input int w);
      return $clog2(w);
   endfunction
endpackage

// File: rtl/exec_mul.sv
// exec_mul: shift-add multiplier, one multiplier bit per cycle, low WIDTH bits
// of the product; the last step is held until the consumer acknowledges it.
module exec_mul #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             ack_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o
);
   localparam int CW = $clog2(WIDTH);

   logic             run_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, acc_d;
   logic             step;

   assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign res_o  = acc_d;
   assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
   assign step   = run_q && !(done_o && !ack_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (start_i) begin
         run_q    <= 1'b1;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= a_i;
         mplier_q <= b_i;
      end else if (step && done_o) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         acc_q <= '0;
      end else if (step) begin
         cnt_q    <= cnt_q + 1'b1;
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end
endmodule

// File: rtl/exec_pipe.sv
// exec_pipe: execute stage with operand forwarding, single-cycle ALU,
// optional iterative multiplier and a valid/ready output register.
module exec_pipe
   import exec_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int RA_W   = 3,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [RA_W-1:0]  in_rs,
   input  logic [RA_W-1:0]  in_rt,
   input  logic             in_b_is_imm,
   input  logic [RA_W-1:0]  in_rd,
   input  logic             in_regwrite,
   input  logic             in_memwrite,
   input  logic             in_memen,
   input  logic             in_memtoreg,
   input  logic             in_dump,
   input  logic             wb_fwd_en,
   input  logic [RA_W-1:0]  wb_fwd_addr,
   input  logic [WIDTH-1:0] wb_fwd_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic [WIDTH-1:0] out_store,
   output logic [RA_W-1:0]  out_rd,
   output logic             out_regwrite,
   output logic             out_memwrite,
   output logic             out_memen,
   output logic             out_memtoreg,
   output logic             out_dump,
   output logic             busy
);
   localparam int SW = log2w(WIDTH);

   state_e           state_q, state_d;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_res_q, out_store_q, pend_store_q;
   logic [RA_W-1:0]  out_rd_q, pend_rd_q;
   ctrl_t            out_ctl_q, pend_ctl_q, in_ctl;
   logic [WIDTH-1:0] opa, opb, alu, mul_res;
   logic [2*WIDTH-1:0] rot;
   logic [SW-1:0]    sh;
   logic             own_ok, out_free, acc, is_mul, mul_start, mul_ack, mul_done, mul_fin;

   assign in_ctl = {in_regwrite, in_memwrite, in_memen, in_memtoreg, in_dump};

   // Loads sitting in the output register are never forwarded; upstream stalls for them.
   assign own_ok = out_valid_q && out_ctl_q.regwrite && !out_ctl_q.memtoreg;
   assign opa = (own_ok && out_rd_q == in_rs) ? out_res_q :
                (wb_fwd_en && wb_fwd_addr == in_rs) ? wb_fwd_data : in_a;
   assign opb = in_b_is_imm ? in_b :
                (own_ok && out_rd_q == in_rt) ? out_res_q :
                (wb_fwd_en && wb_fwd_addr == in_rt) ? wb_fwd_data : in_b;

   assign sh  = opb[SW-1:0];
   assign rot = {opa, opa} << sh;

   always_comb begin
      alu = '0;
      case (in_op)
         OP_ADD:   alu = opa + opb;
         OP_SUB:   alu = opa - opb;
         OP_AND:   alu = opa & opb;
         OP_OR:    alu = opa | opb;
         OP_XOR:   alu = opa ^ opb;
         OP_SLL:   alu = opa << sh;
         OP_SRL:   alu = opa >> sh;
         OP_SRA:   alu = $signed(opa) >>> sh;
         OP_ROL:   alu = rot[2*WIDTH-1:WIDTH];
         OP_SLT:   alu = {{(WIDTH-1){1'b0}}, $signed(opa) < $signed(opb)};
         OP_SEQ:   alu = {{(WIDTH-1){1'b0}}, opa == opb};
         OP_SLE:   alu = {{(WIDTH-1){1'b0}}, $signed(opa) <= $signed(opb)};
         OP_PASSA: alu = opa;
         OP_PASSB: alu = opb;
         OP_MUL:   alu = opb;
         default:  alu = '0;
      endcase
   end

   assign out_free  = !out_valid_q || out_ready;
   assign in_ready  = (state_q == ST_IDLE) && out_free;
   assign acc       = in_valid && in_ready;
   assign is_mul    = (MUL_EN != 0) && (in_op == OP_MUL);
   assign mul_start = acc && is_mul;
   assign mul_ack   = (state_q == ST_MUL) && out_free;
   assign mul_fin   = mul_done && mul_ack;

   always_comb begin
      state_d = mul_start ? ST_MUL : mul_fin ? ST_IDLE : state_q;
   end

   generate
      if (MUL_EN != 0) begin : g_mul
         exec_mul #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst     (rst),
            .start_i (mul_start),
            .ack_i   (mul_ack),
            .a_i     (opa),
            .b_i     (opb),
            .done_o  (mul_done),
            .res_o   (mul_res)
         );
      end else begin : g_nomul
         assign mul_done = 1'b0;
         assign mul_res  = '0;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         out_valid_q  <= 1'b0;
         out_res_q    <= '0;
         out_store_q  <= '0;
         out_rd_q     <= '0;
         out_ctl_q    <= '0;
         pend_store_q <= '0;
         pend_rd_q    <= '0;
         pend_ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         if (acc && !is_mul) begin
            out_valid_q <= 1'b1;
            out_res_q   <= alu;
            out_store_q <= opb;
            out_rd_q    <= in_rd;
            out_ctl_q   <= in_ctl;
         end else if (mul_fin) begin
            out_valid_q <= 1'b1;
            out_res_q   <= mul_res;
            out_store_q <= pend_store_q;
            out_rd_q    <= pend_rd_q;
            out_ctl_q   <= pend_ctl_q;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (mul_start) begin
            pend_store_q <= opb;
            pend_rd_q    <= in_rd;
            pend_ctl_q   <= in_ctl;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_res      = out_res_q;
   assign out_store    = out_store_q;
   assign out_rd       = out_rd_q;
   assign out_regwrite = out_ctl_q.regwrite;
   assign out_memwrite = out_ctl_q.memwrite;
   assign out_memen    = out_ctl_q.memen;
   assign out_memtoreg = out_ctl_q.memtoreg;
   assign out_dump     = out_ctl_q.dump;
   assign busy         = (state_q == ST_MUL);
endmodule

// File: doc/exec_pipe.md
EXEC_PIPE -- requirements
Module: exec_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal 8..32).
REQ-002 Parameter RA_W, default 3, register-address width.
REQ-003 Parameter MUL_EN, default 1; 0 removes the iterative multiplier, and OP_MUL then behaves as OP_PASSB.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  issue slot holds an operation.
REQ-007 in_ready  out  1  block accepts the issue slot this cycle.
REQ-008 in_op  in  4  operation code, encodings defined in exec_pkg.
REQ-009 in_a, in_b  in  WIDTH  register-file operand values (Rs, Rt/immediate).
REQ-010 in_rs, in_rt  in  RA_W  source addresses, used for forwarding.
REQ-011 in_b_is_imm  in  1  in_b is an immediate, so in_rt forwarding is suppressed.
REQ-012 in_rd  in  RA_W  destination address.
REQ-013 in_regwrite, in_memwrite, in_memen, in_memtoreg, in_dump  in  1 each  control bits carried with the operation.
REQ-014 wb_fwd_en  in  1  writeback stage is writing a register.
REQ-015 wb_fwd_addr  in  RA_W  register address written by writeback.
REQ-016 wb_fwd_data  in  WIDTH  data written by writeback.
REQ-017 out_valid  out  1  output register holds a result.
REQ-018 out_ready  in  1  downstream (memory stage) accepts the result.
REQ-019 out_res  out  WIDTH  ALU or multiply result.
REQ-020 out_store  out  WIDTH  forwarded B operand, used as store data.
REQ-021 out_rd  out  RA_W  carried destination address.
REQ-022 out_regwrite, out_memwrite, out_memen, out_memtoreg, out_dump  out  1 each  carried control bits.
REQ-023 busy  out  1  multiplier iterating.

Function
REQ-024 Ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, ROL, SLT (signed), SEQ, SLE (signed), PASSA, PASSB, MUL; any other code shall produce result 0.
- Arithmetic wraps modulo 2^WIDTH.
- Shift amount is in_b[log2(WIDTH)-1:0].
- Compare ops return 1 or 0, zero-extended.
REQ-025 in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-026 An operation is accepted when in_valid && in_ready.
REQ-027 Operand forwarding priority, per operand:
- 1st: own output register, when out_valid && out_regwrite && !out_memtoreg && out_rd==src.
- 2nd: writeback, when wb_fwd_en && wb_fwd_addr==src.
- Otherwise: the input value.
REQ-028 A load in the output register matching a source is not forwarded; the upstream hazard unit stalls for loads.
REQ-029 Forwarding does not treat register 0 specially.
REQ-030 Single-cycle ops: result and all carried fields are loaded into the output register at the accepting edge; out_valid is 1 the following cycle (latency 1).
REQ-031 FSM states IDLE, MUL.
- An accepted MUL moves IDLE->MUL, latching the forwarded operands and the carried fields.
- Shift-add runs 1 bit per cycle for WIDTH cycles, then the result is written to the output register and the state returns to IDLE.
- MUL latency is WIDTH+1 cycles from accept to out_valid.
REQ-032 MUL result is the low WIDTH bits of the product.
REQ-033 busy = (state==MUL).
REQ-034 The MUL->IDLE transition shall not occur while out_valid && !out_ready; the completed product is held until the output register frees.
REQ-035 Output register hold rule:
- out_valid && !out_ready: all out_* held stable.
- out_ready with no new result: out_valid clears.
REQ-036 A new result and out_ready in the same cycle: the new result replaces the old one with no bubble.
REQ-037 in_valid while in_ready=0: nothing is accepted, and upstream must hold its inputs.

Reset
REQ-038 rst asserted asynchronously forces:
- state=IDLE;
- out_valid=0, busy=0;
- out_res, out_store, out_rd = 0;
- all out_* control bits = 0;
- multiplier accumulator and counter = 0.
REQ-039 rst during MUL abandons the operation; no result is ever emitted for it.
REQ-040 in_ready is 1 in the first cycle after rst deasserts.

Structure
REQ-041 exec_pkg holds: op-code constants, FSM state encoding, and a function returning log2(WIDTH).
REQ-042 The iterative multiplier is a sub-module named exec_mul (start/done handshake, WIDTH-parametrised), instantiated only when MUL_EN=1.
REQ-043 Combinational ALU logic stays inside exec_pipe.

Verification
REQ-044 ADD a=0x7FFF b=0x0001 -> out_res=0x8000 one cycle later; SUB 0x0000-0x0001 -> 0xFFFF.
REQ-045 Forwarding and priority checks:
- ADD r1<=5+3, then ADD r2<=r1+1 back-to-back -> out_res=9 via own-register forwarding.
- Same source also on writeback with data 100 -> own register still wins (9).
REQ-046 MUL 0x0012*0x0034 (WIDTH=16) -> busy for 16 cycles, in_ready=0 throughout, out_res=0x03A8 at cycle 17; 0xFFFF*0xFFFF -> 0x0001.
REQ-047 out_ready held low 3 cycles with out_valid=1 -> out_* stable and in_ready=0; release -> a queued op is accepted the same cycle.
REQ-048 rst pulsed at MUL cycle 5 -> out_valid=0 and busy=0 immediately; no stale result after release; next ADD 2+2 -> 4.
REQ-049 WIDTH=32 build: SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLT -1<1 -> 1.
